ifu_fetch: RTL and testbench

Instruction fetch stage of the single-cycle/early-pipeline core. It owns the architectural fetch PC, issues in-order word fetches to instruction memory over a valid/ready request and valid response interface, and buffers up to two fetched instructions with their PCs for decode. The decode/ALU path consumes the PC and instruction. Execute returns taken-branch/JAL/JALR targets on the redirect port, and the block squashes everything younger.

---
 rtl/ifu_fetch_if.sv | 22 ++
 rtl/ifu_fetch.sv | 88 ++++++++
 tb/tb_ifu_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: redirect, instruction-memory and decode-side signals of the fetch stage
interface ifu_fetch_if #(parameter int PC_WIDTH = 64);
    logic                redirect_valid_i;
    logic [PC_WIDTH-1:0] redirect_pc_i;
    logic                imem_req_valid_o;
    logic                imem_req_ready_i;
    logic [PC_WIDTH-1:0] imem_req_addr_o;
    logic                imem_rsp_valid_i;
    logic [31:0]         imem_rsp_data_i;
    logic                inst_valid_o;
    logic                inst_ready_i;
    logic [31:0]         inst_o;
    logic [PC_WIDTH-1:0] inst_pc_o;
    modport master (
        input  redirect_valid_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i,
        output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o
    );
    modport slave (
        output redirect_valid_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i,
        input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: in-order word fetch with a 2-entry fill queue and redirect squash of younger work
module ifu_fetch #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    ifu_fetch_if.master   bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0][1:0]          r_st;
    logic [1:0][PC_WIDTH-1:0] r_pc;
    logic [1:0][31:0]         r_inst;
    logic                     r_head;
    logic                     r_tail;
    logic [1:0]               r_drop;
    logic [PC_WIDTH-1:0]      r_fetch_pc;

    logic       w_head_full;
    logic       w_pop;
    logic       w_acc;
    logic       w_fill;
    logic       w_fill_idx;
    logic [1:0] w_occ;
    logic [1:0] w_npend;
    logic [2:0] w_drop_sum;
    logic [2:0] w_drop_redir;
    logic       w_unused;

    always_comb begin
        w_occ        = {1'b0, r_st[0] != S_EMPTY} + {1'b0, r_st[1] != S_EMPTY};
        w_npend      = {1'b0, r_st[0] == S_PEND} + {1'b0, r_st[1] == S_PEND};
        w_head_full  = r_st[r_head] == S_FULL;
        bus.inst_valid_o = w_head_full & ~bus.redirect_valid_i;
        bus.inst_o       = w_head_full ? r_inst[r_head] : 32'd0;
        bus.inst_pc_o    = w_head_full ? r_pc[r_head] : '0;
        w_pop        = bus.inst_valid_o & bus.inst_ready_i;
        // a slot freed by this cycle's pop already counts as credit for a new request
        bus.imem_req_valid_o = rst_n_i & ~bus.redirect_valid_i &
                               (({1'b0, w_occ} + {1'b0, r_drop} - {2'b0, w_pop}) < 3'd2);
        bus.imem_req_addr_o  = r_fetch_pc;
        w_acc        = bus.imem_req_valid_o & bus.imem_req_ready_i;
        w_fill_idx   = (r_st[r_head] == S_PEND) ? r_head : ~r_head;
        w_fill       = bus.imem_rsp_valid_i & (r_drop == 2'd0) & (w_npend != 2'd0);
        w_drop_sum   = {1'b0, r_drop} + {1'b0, w_npend};
        w_drop_redir = (bus.imem_rsp_valid_i && w_drop_sum != 3'd0) ? w_drop_sum - 3'd1 : w_drop_sum;
        w_unused     = ^bus.redirect_pc_i[1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_st       <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_drop     <= 2'd0;
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid_i) begin
            r_st       <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_drop     <= w_drop_redir[1:0];
            r_fetch_pc <= {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else begin
            if (bus.imem_rsp_valid_i && r_drop != 2'd0)
                r_drop <= r_drop - 2'd1;
            if (w_pop) begin
                r_st[r_head] <= S_EMPTY;
                r_head       <= ~r_head;
            end
            if (w_fill) begin
                r_st[w_fill_idx]   <= S_FULL;
                r_inst[w_fill_idx] <= bus.imem_rsp_data_i;
            end
            // ordered last so a same-cycle pop of the tail slot is overridden by the new request
            if (w_acc) begin
                r_st[r_tail] <= S_PEND;
                r_pc[r_tail] <= r_fetch_pc;
                r_tail       <= ~r_tail;
                r_fetch_pc   <= r_fetch_pc + PC_WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of ifu_fetch against a fixed-latency in-order memory
module tb_ifu_fetch;
    typedef struct {
        logic [63:0] a;
        int          due;
    } mreq_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   lat;

    mreq_t       mq[$];
    logic [63:0] acc_q[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_in[$];
    logic [63:0] w_acc_q[$];

    ifu_fetch_if #(.PC_WIDTH(64)) f ();
    ifu_fetch_if #(.PC_WIDTH(64)) w ();

    ifu_fetch u_dut (.clk_i(clk), .rst_n_i(rst_n), .bus(f));
    ifu_fetch #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (.clk_i(clk), .rst_n_i(rst_n), .bus(w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f.redirect_valid_i = 1'b0;
        f.imem_rsp_valid_i = 1'b0;
        mq.delete();
        acc_q.delete();
        pop_pc.delete();
        pop_in.delete();
        w_acc_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid", f.imem_req_valid_o, 1'b0);
        chk("rst_req_addr", f.imem_req_addr_o, 64'h8000_0000);
        chk("rst_inst_valid", f.inst_valid_o, 1'b0);
        chk("rst_inst", f.inst_o, 32'd0);
        chk("rst_inst_pc", f.inst_pc_o, 64'd0);
        chk("rst_wrap_addr", w.imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic step(input logic rd, input logic [63:0] rpc, input logic ir);
        @(negedge clk);
        cyc++;
        f.redirect_valid_i = rd;
        f.redirect_pc_i    = rpc;
        f.inst_ready_i     = ir;
        f.imem_req_ready_i = 1'b1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            f.imem_rsp_valid_i = 1'b1;
            f.imem_rsp_data_i  = mdata(mq[0].a);
            mq.delete(0);
        end else begin
            f.imem_rsp_valid_i = 1'b0;
            f.imem_rsp_data_i  = 32'd0;
        end
        #1;
        if (f.imem_req_valid_o && f.imem_req_ready_i) begin
            acc_q.push_back(f.imem_req_addr_o);
            mq.push_back('{a: f.imem_req_addr_o, due: cyc + lat});
        end
        if (f.inst_valid_o && f.inst_ready_i) begin
            pop_pc.push_back(f.inst_pc_o);
            pop_in.push_back(f.inst_o);
        end
        if (w.imem_req_valid_o)
            w_acc_q.push_back(w.imem_req_addr_o);
    endtask

    initial begin
        rst_n = 1'b0;
        f.redirect_valid_i = 1'b0;
        f.redirect_pc_i    = '0;
        f.imem_req_ready_i = 1'b1;
        f.imem_rsp_valid_i = 1'b0;
        f.imem_rsp_data_i  = '0;
        f.inst_ready_i     = 1'b1;
        w.redirect_valid_i = 1'b0;
        w.redirect_pc_i    = '0;
        w.imem_req_ready_i = 1'b1;
        w.imem_rsp_valid_i = 1'b0;
        w.imem_rsp_data_i  = '0;
        w.inst_ready_i     = 1'b0;

        // streaming with 1-cycle memory, plus the wrap-around instance
        lat = 1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 64'd0, 1'b1);
            chk("t1_req_valid", f.imem_req_valid_o, 1'b1);
            chk("t1_req_addr", f.imem_req_addr_o, 64'h8000_0000 + 64'(4 * c));
            chk("t1_inst_valid", f.inst_valid_o, c >= 2);
            if (c >= 2) begin
                chk("t1_inst_pc", f.inst_pc_o, 64'h8000_0000 + 64'(4 * (c - 2)));
                chk("t1_inst", f.inst_o, mdata(64'h8000_0000 + 64'(4 * (c - 2))));
            end
        end
        chk("wrap_count", w_acc_q.size(), 2);
        chk("wrap_first", w_acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_second", w_acc_q[1], 64'd0);

        // asynchronous reset mid-cycle with a FULL head
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_inst_valid", f.inst_valid_o, 1'b0);
        chk("async_inst_pc", f.inst_pc_o, 64'd0);
        chk("async_req_valid", f.imem_req_valid_o, 1'b0);
        chk("async_req_addr", f.imem_req_addr_o, 64'h8000_0000);
        do_reset();
        step(1'b0, 64'd0, 1'b1);
        chk("restart_addr", f.imem_req_addr_o, 64'h8000_0000);
        chk("restart_valid", f.imem_req_valid_o, 1'b1);
        step(1'b0, 64'd0, 1'b1);
        chk("restart_iv1", f.inst_valid_o, 1'b0);
        step(1'b0, 64'd0, 1'b1);
        chk("restart_pc", f.inst_pc_o, 64'h8000_0000);

        // decode backpressure for 5 cycles
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b0, 64'd0, 1'b0);
        chk("bp_req_valid", f.imem_req_valid_o, 1'b0);
        chk("bp_head_pc", f.inst_pc_o, 64'h8000_0000);
        chk("bp_head_valid", f.inst_valid_o, 1'b1);
        chk("bp_acc_count", acc_q.size(), 2);
        chk("bp_pop_count", pop_pc.size(), 0);
        for (int c = 0; c < 4; c++) step(1'b0, 64'd0, 1'b1);
        chk("bp_pops", pop_pc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_pop_pc", pop_pc[i], 64'h8000_0000 + 64'(4 * i));
            chk("bp_pop_inst", pop_in[i], mdata(64'h8000_0000 + 64'(4 * i)));
        end

        // redirect with two PENDING entries and 3-cycle memory
        lat = 3;
        do_reset();
        step(1'b0, 64'd0, 1'b1);
        step(1'b0, 64'd0, 1'b1);
        step(1'b1, 64'h8000_0103, 1'b1);
        chk("rd2_inst_valid", f.inst_valid_o, 1'b0);
        chk("rd2_req_valid", f.imem_req_valid_o, 1'b0);
        step(1'b0, 64'd0, 1'b1);
        chk("rd2_c3_valid", f.imem_req_valid_o, 1'b0);
        chk("rd2_c3_addr", f.imem_req_addr_o, 64'h8000_0100);
        step(1'b0, 64'd0, 1'b1);
        chk("rd2_c4_valid", f.imem_req_valid_o, 1'b1);
        chk("rd2_c4_addr", f.imem_req_addr_o, 64'h8000_0100);
        for (int c = 5; c < 10; c++) step(1'b0, 64'd0, 1'b1);
        chk("rd2_pops", pop_pc.size(), 2);
        chk("rd2_pop0_pc", pop_pc[0], 64'h8000_0100);
        chk("rd2_pop0_inst", pop_in[0], mdata(64'h8000_0100));
        chk("rd2_pop1_pc", pop_pc[1], 64'h8000_0104);
        chk("rd2_acc2", acc_q[2], 64'h8000_0100);

        // redirect in the same cycle as the head response
        lat = 2;
        do_reset();
        step(1'b0, 64'd0, 1'b1);
        step(1'b0, 64'd0, 1'b1);
        step(1'b1, 64'h8000_0200, 1'b1);
        chk("rdh_inst_valid", f.inst_valid_o, 1'b0);
        step(1'b0, 64'd0, 1'b1);
        chk("rdh_c3_valid", f.imem_req_valid_o, 1'b1);
        chk("rdh_c3_addr", f.imem_req_addr_o, 64'h8000_0200);
        for (int c = 4; c < 8; c++) step(1'b0, 64'd0, 1'b1);
        chk("rdh_pops", pop_pc.size(), 2);
        chk("rdh_pop0_pc", pop_pc[0], 64'h8000_0200);
        chk("rdh_pop0_inst", pop_in[0], mdata(64'h8000_0200));
        chk("rdh_pop1_pc", pop_pc[1], 64'h8000_0204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
